// File: rtl/calc_alu_if.sv
// Request/response bundle between a calculator front end and calc_alu.
interface calc_alu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        error;
    logic        busy;
    logic        done;

    modport master (
        output start, op, a, b,
        input  result, error, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, error, busy, done
    );
endinterface

// File: rtl/calc_alu.sv
// Signed 32-bit calculator: single-cycle add/sub, 32-step shift-add multiply and
// restoring divide on magnitudes, followed by a sign-fix/overflow stage.
module calc_alu (
    input  logic        clock,
    input  logic        reset,
    calc_alu_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ADDSUB, ITER, FIX} state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] result_q;
    logic        error_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        add_ovf;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_fit;
    logic [31:0] div_diff;
    logic        is_div;
    logic [63:0] mag;
    logic        neg;
    logic        fix_err;
    logic [31:0] fix_val;

    // Subtraction reuses the adder with an inverted operand and carry-in; the
    // overflow test looks at the operand signs the adder actually sees.
    assign addend  = op_q[0] ? ~b_q : b_q;
    assign sum     = a_q + addend + {31'b0, op_q[0]};
    assign add_ovf = (a_q[31] == addend[31]) && (sum[31] != a_q[31]);

    assign mag_a_in = bus.a[31] ? -bus.a : bus.a;
    assign mag_b    = b_q[31] ? -b_q : b_q;
    assign is_div   = op_q[1] & op_q[0];

    // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign div_shift = {acc[63:32], acc[31]};
    assign div_fit   = div_shift >= {1'b0, mag_b};
    assign div_diff  = div_shift[31:0] - mag_b;

    assign mag     = is_div ? {32'b0, acc[31:0]} : acc;
    assign neg     = a_q[31] ^ b_q[31];
    assign fix_err = (neg ? (mag > 64'h0000_0000_8000_0000) : (mag > 64'h0000_0000_7FFF_FFFF))
                   || (is_div && (b_q == 32'd0));
    assign fix_val = neg ? -mag[31:0] : mag[31:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            count    <= '0;
            acc      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        op_q   <= bus.op;
                        acc    <= {32'b0, mag_a_in};
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= bus.op[1] ? ITER : ADDSUB;
                    end
                end
                ADDSUB: begin
                    result_q <= add_ovf ? 32'd0 : sum;
                    error_q  <= add_ovf;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                ITER: begin
                    if (is_div)
                        acc <= {(div_fit ? div_diff : div_shift[31:0]), acc[30:0], div_fit};
                    else
                        acc <= {mul_sum, acc[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    result_q <= fix_err ? 32'd0 : fix_val;
                    error_q  <= fix_err;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    count    <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.error  = error_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
